// File: rtl/decoder_slot_sequencer.sv
// Strobe sequencer for a 74138-style 3-to-8 decoder.
// Walks first_slot..last_slot (with wrap) with a programmable dwell and a one-tick guard gap.
module decoder_slot_sequencer #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               start,
    input  logic               abort,
    input  logic [SEL_W-1:0]   first_slot,
    input  logic [SEL_W-1:0]   last_slot,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               g1,
    output logic               g2a_n,
    output logic               g2b_n,
    output logic               busy,
    output logic               done,
    output logic [SEL_W-1:0]   slot_idx
);

    localparam logic [SEL_W-1:0]   SelOne   = SEL_W'(1);
    localparam logic [DWELL_W-1:0] DwellOne = DWELL_W'(1);

    typedef enum logic [1:0] {StIdle, StActive, StGuard, StDone} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               en_q, en_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ce && start) begin
                    sel_d   = first_slot;
                    last_d  = last_slot;
                    dwell_d = dwell;
                    cnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (ce) begin
                    if (cnt_q == dwell_q) begin
                        idx_d = idx_q + SelOne;
                        if (sel_q == last_q) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            // sel moves only as the enables drop
                            state_d = StGuard;
                            sel_d   = sel_q + SelOne;
                        end
                    end else begin
                        cnt_d = cnt_q + DwellOne;
                    end
                end
            end
            StGuard: begin
                if (ce) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end

        // Enables come from a dedicated flop so the decoder never sees state-decode glitches
        en_d = (state_d == StActive);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
        end
    end

    assign sel      = sel_q;
    assign g1       = en_q;
    assign g2a_n    = ~en_q;
    assign g2b_n    = ~en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign slot_idx = idx_q;

endmodule

// File: tb/tb_decoder_slot_sequencer.sv
// Bench for decoder_slot_sequencer: a window monitor pops expected (slot, length) pairs
// from a queue filled when each sequence is launched; tasks check control timing inline.
module tb_decoder_slot_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       start;
    logic       abort;
    logic [2:0] first_slot;
    logic [2:0] last_slot;
    logic [3:0] dwell;
    logic [2:0] sel;
    logic       g1;
    logic       g2a_n;
    logic       g2b_n;
    logic       busy;
    logic       done;
    logic [2:0] slot_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] s;
        int         len;
    } win_t;

    win_t exp_q[$];

    decoder_slot_sequencer #(
        .SEL_W  (3),
        .DWELL_W(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .start     (start),
        .abort     (abort),
        .first_slot(first_slot),
        .last_slot (last_slot),
        .dwell     (dwell),
        .sel       (sel),
        .g1        (g1),
        .g2a_n     (g2a_n),
        .g2b_n     (g2b_n),
        .busy      (busy),
        .done      (done),
        .slot_idx  (slot_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1);
    end

    // Enable-window monitor: each window must match the next queued slot and length,
    // and sel must not move while the decoder stays enabled.
    initial begin : monitor
        logic       en_now;
        logic       en_prev;
        logic [2:0] sel_prev;
        logic [2:0] win_sel;
        int         win_len;
        win_t       e;
        en_prev  = 1'b0;
        sel_prev = '0;
        win_sel  = '0;
        win_len  = 0;
        forever begin
            @(negedge clk);
            en_now = (g1 === 1'b1) && (g2a_n === 1'b0) && (g2b_n === 1'b0);
            if (reset_n === 1'b1 && g2a_n !== g2b_n) begin
                errors++;
                $display("FAIL g2_equal: g2a_n=%b g2b_n=%b required equal", g2a_n, g2b_n);
            end
            if (en_now && en_prev && sel !== sel_prev) begin
                errors++;
                $display("FAIL sel_stable: sel=%0d while enabled, required %0d", sel, sel_prev);
            end
            if (en_now && !en_prev) begin
                win_sel = sel;
                win_len = 1;
            end else if (en_now) begin
                win_len++;
            end
            if (!en_now && en_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL window: unexpected window sel=%0d len=%0d", win_sel, win_len);
                end else begin
                    e = exp_q.pop_front();
                    if (win_sel !== e.s || win_len != e.len) begin
                        errors++;
                        $display("FAIL window: got sel=%0d len=%0d, required sel=%0d len=%0d",
                                 win_sel, win_len, e.s, e.len);
                    end
                end
            end
            en_prev  = en_now;
            sel_prev = sel;
        end
    end

    // Call at a negedge; start is sampled on the following posedge (E0) and the task
    // returns at the negedge after E0.
    task automatic do_start(input logic [2:0] f, input logic [2:0] l, input logic [3:0] d);
        first_slot = f;
        last_slot  = l;
        dwell      = d;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns k such that done was seen after edge Ek (relative to the caller's last edge); -1 on timeout.
    task automatic wait_done(input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({g1, g2a_n, g2b_n, busy, done} !== 5'b01100 || sel !== 3'd0 || slot_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_init: g1/g2a/g2b/busy/done=%b sel=%0d idx=%0d required 01100 0 0",
                     {g1, g2a_n, g2b_n, busy, done}, sel, slot_idx);
        end
        reset_n = 1'b1;
        @(negedge clk);
        exp_q.push_back('{s: 3'd3, len: 3});
        do_start(3'd3, 3'd3, 4'd7);
        checks++;
        if (g1 !== 1'b1 || sel !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_active: g1=%b sel=%0d busy=%b required 1 3 1", g1, sel, busy);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({g1, g2a_n, g2b_n, busy, done} !== 5'b01100 || sel !== 3'd0 || slot_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: g1/g2a/g2b/busy/done=%b sel=%0d idx=%0d required 01100 0 0",
                     {g1, g2a_n, g2b_n, busy, done}, sel, slot_idx);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int k;
        exp_q.push_back('{s: 3'd2, len: 2});
        exp_q.push_back('{s: 3'd3, len: 2});
        exp_q.push_back('{s: 3'd4, len: 2});
        do_start(3'd2, 3'd4, 4'd1);
        checks++;
        if (busy !== 1'b1 || g1 !== 1'b1 || sel !== 3'd2 || slot_idx !== 3'd0) begin
            errors++;
            $display("FAIL basic_start: busy=%b g1=%b sel=%0d idx=%0d required 1 1 2 0",
                     busy, g1, sel, slot_idx);
        end
        wait_done(20, k);
        checks++;
        if (k != 8 || slot_idx !== 3'd3 || g1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done at E%0d idx=%0d g1=%b required E8 3 0",
                     k, slot_idx, g1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || slot_idx !== 3'd3) begin
            errors++;
            $display("FAIL basic_idle: busy=%b done=%b idx=%0d required 0 0 3", busy, done, slot_idx);
        end
    endtask

    task automatic test_wrap_full();
        int k;
        logic [2:0] s;
        exp_q.push_back('{s: 3'd6, len: 1});
        exp_q.push_back('{s: 3'd7, len: 1});
        exp_q.push_back('{s: 3'd0, len: 1});
        exp_q.push_back('{s: 3'd1, len: 1});
        do_start(3'd6, 3'd1, 4'd0);
        wait_done(20, k);
        checks++;
        if (k != 7 || slot_idx !== 3'd4) begin
            errors++;
            $display("FAIL wrap_done: done at E%0d idx=%0d required E7 4", k, slot_idx);
        end
        @(negedge clk);
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{s: s, len: 1});
            s = s + 3'd1;
        end
        do_start(3'd0, 3'd7, 4'd0);
        wait_done(40, k);
        // 8 completed slots wrap the 3-bit slot counter to 0
        checks++;
        if (k != 15 || slot_idx !== 3'd0) begin
            errors++;
            $display("FAIL full_done: done at E%0d idx=%0d required E15 0", k, slot_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_ce_throttle();
        int bad;
        exp_q.push_back('{s: 3'd5, len: 12});
        ce = 1'b1;
        first_slot = 3'd5;
        last_slot  = 3'd5;
        dwell      = 4'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ce    = 1'b0;
        bad   = 0;
        for (int p = 0; p < 3; p++) begin
            repeat (3) begin
                @(negedge clk);
                if (sel !== 3'd5 || g1 !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                    slot_idx !== 3'd0) bad++;
            end
            ce = 1'b1;
            @(negedge clk);
            ce = 1'b0;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ce_frozen: %0d cycles with outputs moving, required 0", bad);
        end
        checks++;
        if (done !== 1'b1 || g1 !== 1'b0 || slot_idx !== 3'd1) begin
            errors++;
            $display("FAIL ce_done: done=%b g1=%b idx=%0d required 1 0 1", done, g1, slot_idx);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ce_done_exit: busy=%b done=%b required 0 0 with ce low", busy, done);
        end
        ce = 1'b1;
    endtask

    task automatic test_abort();
        int k;
        int saw_done;
        exp_q.push_back('{s: 3'd0, len: 4});
        exp_q.push_back('{s: 3'd1, len: 4});
        exp_q.push_back('{s: 3'd2, len: 2});
        do_start(3'd0, 3'd7, 4'd3);
        saw_done = 0;
        repeat (11) begin
            @(negedge clk);
            if (done === 1'b1) saw_done++;
        end
        checks++;
        if (sel !== 3'd2 || g1 !== 1'b1 || slot_idx !== 3'd2) begin
            errors++;
            $display("FAIL abort_pre: sel=%0d g1=%b idx=%0d required 2 1 2", sel, g1, slot_idx);
        end
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (g1 !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || slot_idx !== 3'd0 || saw_done != 0) begin
            errors++;
            $display("FAIL abort_stop: g1=%b busy=%b done=%b idx=%0d early_done=%0d required 0 0 0 0 0",
                     g1, busy, done, slot_idx, saw_done);
        end
        // abort still high in IDLE together with start: start must win
        exp_q.push_back('{s: 3'd4, len: 1});
        do_start(3'd4, 3'd4, 4'd0);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || sel !== 3'd4 || g1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: busy=%b sel=%0d g1=%b required 1 4 1", busy, sel, g1);
        end
        wait_done(10, k);
        checks++;
        if (k != 1 || slot_idx !== 3'd1) begin
            errors++;
            $display("FAIL abort_new_done: done at E%0d idx=%0d required E1 1", k, slot_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back('{s: 3'd1, len: 2});
            exp_q.push_back('{s: 3'd2, len: 2});
            exp_q.push_back('{s: 3'd3, len: 2});
        end
        first_slot = 3'd1;
        last_slot  = 3'd3;
        dwell      = 4'd1;
        start      = 1'b1;
        @(negedge clk);
        // inputs change while busy; captured fields must not follow
        first_slot = 3'd6;
        last_slot  = 3'd6;
        dwell      = 4'd5;
        wait_done(20, k);
        checks++;
        if (k != 8 || slot_idx !== 3'd3) begin
            errors++;
            $display("FAIL busy_start_done: done at E%0d idx=%0d required E8 3", k, slot_idx);
        end
        first_slot = 3'd1;
        last_slot  = 3'd3;
        dwell      = 4'd1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || g1 !== 1'b0) begin
            errors++;
            $display("FAIL done_edge_start: busy=%b g1=%b required 0 0", busy, g1);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || sel !== 3'd1 || slot_idx !== 3'd0) begin
            errors++;
            $display("FAIL idle_start: busy=%b sel=%0d idx=%0d required 1 1 0", busy, sel, slot_idx);
        end
        wait_done(20, k);
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL second_done: done at E%0d required E8", k);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        ce         = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        first_slot = '0;
        last_slot  = '0;
        dwell      = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap_full();
        test_ce_throttle();
        test_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL windows_left: %0d expected windows never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
